instruction_issuer: RTL and testbench
=====================================

INSTRUCTION_ISSUER -- requirements
Module: instruction_issuer

Interface
REQ-001 Parameter DEPTH, default 16, meaning: program/result buffer entries.
REQ-002 Parameter TIMEOUT, default 32, meaning: max WAIT cycles per instruction before abort.
REQ-003 Parameter BLANK, default 2, meaning: WAIT cycles during which output_sig is ignored.
REQ-004 Port clk  input  1  single clock; all logic on posedge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port load_valid  input  1  write load_data into program buffer at load_addr.
REQ-007 Port load_addr  input  4  program buffer write index.
REQ-008 Port load_data  input  34  instruction word: [33:31] opcode, [30:26] rd addr1, [25:21] rd addr2, [20:16] wr addr, [15:0] data.
REQ-009 Port start  input  1  begin executing entries 0..prog_len-1.
REQ-010 Port prog_len  input  5  instruction count, sampled on accepted start.
REQ-011 Port instruct  output  34  instruction presented to processor.
REQ-012 Port instruct_sig  output  1  active-low execute request; high = idle.
REQ-013 Port output_sig  input  1  processor completion flag.
REQ-014 Port read_out1  input  16  processor read port 1 data.
REQ-015 Port read_out2  input  16  processor read port 2 data.
REQ-016 Port res_addr  input  4  result buffer read index.
REQ-017 Port res_data  output  32  {read_out1, read_out2} captured for entry res_addr, combinational read.
REQ-018 Port busy  output  1  high in any state except IDLE.
REQ-019 Port done  output  1  one-cycle pulse at end of run.
REQ-020 Port timeout_err  output  1  sticky abort flag, cleared by next accepted start.
REQ-021 Port issued_count  output  5  instructions completed in current/last run.

Function
REQ-022 FSM states: IDLE, ISSUE, WAIT, GAP, FINISH.
REQ-023 IDLE: start=1 accepted; latch len = min(prog_len,16), pc=0, issued_count=0, timeout_err=0; len=0 -> FINISH, else ISSUE.
REQ-024 ISSUE (1 cycle): instruct <= prog[pc], instruct_sig <= 0, wait_cnt <= 0; -> WAIT.
REQ-025 WAIT: instruct and instruct_sig=0 held stable; wait_cnt increments each cycle.
REQ-026 WAIT: output_sig ignored while wait_cnt < BLANK (covers registered stale completion flag).
REQ-027 WAIT: output_sig=1 with wait_cnt >= BLANK -> result[pc] <= {read_out1, read_out2}, issued_count+1, instruct_sig <= 1; -> GAP.
REQ-028 WAIT: wait_cnt = TIMEOUT-1 with no valid completion -> timeout_err <= 1, instruct_sig <= 1, no capture; -> FINISH.
REQ-029 Completion and timeout in same cycle: completion wins.
REQ-030 GAP (1 cycle, instruct_sig=1): pc+1; if pc+1 = len -> FINISH, else ISSUE.
REQ-031 FINISH: done=1 for exactly one cycle, instruct_sig=1; -> IDLE.
REQ-032 Issue latency: start to first instruct_sig low = 2 cycles; minimum per-instruction period = BLANK+3 cycles.
REQ-033 load_valid ignored while busy=1; start ignored while busy=1.
REQ-034 load_valid and start together in IDLE: load committed, start accepted, new word visible to run.
REQ-035 pc and load_addr wrap at DEPTH; prog_len > 16 clamps to 16.

Reset
REQ-036 reset=1 -> state IDLE, instruct=0, instruct_sig=1, busy=0, done=0, timeout_err=0, issued_count=0, pc=0.
REQ-037 Reset mid-run aborts immediately with no done pulse; program and result buffers keep contents.

Verification
REQ-038 Load 3 words, start prog_len=3, processor model completes after 3 cycles each -> 3 issues, issued_count=3, one done pulse, res_data per entry matches model.
REQ-039 Model holds output_sig=1 constantly -> each completion accepted exactly at wait_cnt=BLANK, never earlier.
REQ-040 Model never completes, prog_len=2 -> timeout_err=1 after 32 WAIT cycles, issued_count=0, done pulse, instruct_sig=1.
REQ-041 start with prog_len=0 -> done two cycles later, instruct_sig never low; prog_len=20 -> exactly 16 issues.
REQ-042 reset asserted during WAIT of entry 1 -> next cycle instruct_sig=1, busy=0, no done; restart runs cleanly.
REQ-043 load_valid/start pulsed while busy -> program buffer unchanged, run unaffected.

Source files
------------

// File: rtl/instruction_issuer.sv
`default_nettype none
// ------------------------------------------------------------------------
// instruction_issuer : steps a loaded program through a handshaked
//                      processor and captures each read-port result pair.
// Rev 1.0
// ------------------------------------------------------------------------
module instruction_issuer #(
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 32,
   parameter int BLANK   = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     load_valid,
   input  logic [$clog2(DEPTH)-1:0] load_addr,
   input  logic [33:0]              load_data,
   input  logic                     start,
   input  logic [$clog2(DEPTH):0]   prog_len,
   output logic [33:0]              instruct,
   output logic                     instruct_sig,
   input  logic                     output_sig,
   input  logic [15:0]              read_out1,
   input  logic [15:0]              read_out2,
   input  logic [$clog2(DEPTH)-1:0] res_addr,
   output logic [31:0]              res_data,
   output logic                     busy,
   output logic                     done,
   output logic                     timeout_err,
   output logic [$clog2(DEPTH):0]   issued_count
);

   localparam int AW  = $clog2(DEPTH);
   localparam int LW  = AW + 1;
   localparam int WCW = $clog2(TIMEOUT + BLANK + 1) + 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ISSUE  = 3'd1,
      S_WAIT   = 3'd2,
      S_GAP    = 3'd3,
      S_FINISH = 3'd4
   } state_t;

   state_t         state;
   logic [AW-1:0]  pc;
   logic [LW-1:0]  len;
   logic [WCW-1:0] wait_cnt;
   logic [33:0]    prog_mem [DEPTH];
   logic [31:0]    res_mem  [DEPTH];

   logic           load_en;
   logic           capture;
   logic           expire;
   logic [LW-1:0]  pc_inc;
   logic [LW-1:0]  len_clamped;

   assign load_en     = (state == S_IDLE) && load_valid;
   // The processor's completion flag may still be high from the previous
   // instruction for a few cycles, so it is only trusted after BLANK cycles.
   assign capture     = (state == S_WAIT) && output_sig && (wait_cnt >= WCW'(BLANK));
   assign expire      = (state == S_WAIT) && (wait_cnt == WCW'(TIMEOUT - 1));
   assign pc_inc      = {1'b0, pc} + LW'(1);
   assign len_clamped = (prog_len > LW'(DEPTH)) ? LW'(DEPTH) : prog_len;
   assign busy        = (state != S_IDLE);
   assign res_data    = res_mem[res_addr];

   // Buffers are deliberately not reset so a mid-run abort preserves them.
   always_ff @(posedge clk) begin
      if (!reset && load_en) begin
         prog_mem[load_addr] <= load_data;
      end
      if (!reset && capture) begin
         res_mem[pc] <= {read_out1, read_out2};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         pc           <= '0;
         len          <= '0;
         wait_cnt     <= '0;
         instruct     <= '0;
         instruct_sig <= 1'b1;
         done         <= 1'b0;
         timeout_err  <= 1'b0;
         issued_count <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  len          <= len_clamped;
                  pc           <= '0;
                  issued_count <= '0;
                  timeout_err  <= 1'b0;
                  state        <= (prog_len == '0) ? S_FINISH : S_ISSUE;
               end
            end
            S_ISSUE: begin
               instruct     <= prog_mem[pc];
               instruct_sig <= 1'b0;
               wait_cnt     <= '0;
               state        <= S_WAIT;
            end
            S_WAIT: begin
               if (capture) begin
                  issued_count <= issued_count + LW'(1);
                  instruct_sig <= 1'b1;
                  state        <= S_GAP;
               end else if (expire) begin
                  timeout_err  <= 1'b1;
                  instruct_sig <= 1'b1;
                  state        <= S_FINISH;
               end else begin
                  wait_cnt <= wait_cnt + WCW'(1);
               end
            end
            S_GAP: begin
               pc    <= pc + AW'(1);
               state <= (pc_inc == len) ? S_FINISH : S_ISSUE;
            end
            S_FINISH: begin
               done         <= 1'b1;
               instruct_sig <= 1'b1;
               state        <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instruction_issuer.sv
`default_nettype none
// tb_instruction_issuer : randomized program runs checked against a cycle-timing
// and result model derived from the issuer's handshake rules.
module tb_instruction_issuer;

   localparam int DEPTH   = 16;
   localparam int TIMEOUT = 32;
   localparam int BLANK   = 2;

   logic        clk        = 1'b0;
   logic        reset      = 1'b1;
   logic        load_valid = 1'b0;
   logic [3:0]  load_addr  = '0;
   logic [33:0] load_data  = '0;
   logic        start      = 1'b0;
   logic [4:0]  prog_len   = '0;
   logic        output_sig = 1'b0;
   logic [15:0] read_out1  = '0;
   logic [15:0] read_out2  = '0;
   logic [3:0]  res_addr   = '0;
   logic [33:0] instruct;
   logic        instruct_sig;
   logic [31:0] res_data;
   logic        busy;
   logic        done;
   logic        timeout_err;
   logic [4:0]  issued_count;

   int errors = 0;
   int checks = 0;

   logic [33:0] prog_m [16];
   logic [31:0] res_m  [16];

   instruction_issuer #(
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT),
      .BLANK   (BLANK)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .load_valid   (load_valid),
      .load_addr    (load_addr),
      .load_data    (load_data),
      .start        (start),
      .prog_len     (prog_len),
      .instruct     (instruct),
      .instruct_sig (instruct_sig),
      .output_sig   (output_sig),
      .read_out1    (read_out1),
      .read_out2    (read_out2),
      .res_addr     (res_addr),
      .res_data     (res_data),
      .busy         (busy),
      .done         (done),
      .timeout_err  (timeout_err),
      .issued_count (issued_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [33:0] rand_word();
      return {2'($urandom()), 32'($urandom())};
   endfunction

   task automatic load_word(input int addr, input logic [33:0] w);
      @(negedge clk);
      load_valid = 1'b1;
      load_addr  = 4'(addr);
      load_data  = w;
      @(negedge clk);
      load_valid = 1'b0;
      prog_m[addr] = w;
   endtask

   // Processor answers lat cycles after the request goes low (or always, if always_on).
   // Issue k is expected to go low at cycle 2 + k*(m+3), m = accepted wait count.
   task automatic run(input int plen, input int lat, input bit always_on,
                      input bit disturb, input bit load_with_start, input int reset_at);
      int exp_len, m, exp_issues, exp_done, cyc, lowcnt, nissue, done_hits;
      bit completes, prev_low, seen_done;
      logic [33:0] w;
      exp_len    = (plen > 16) ? 16 : plen;
      m          = always_on ? BLANK : ((lat > BLANK) ? lat : BLANK);
      completes  = (m <= TIMEOUT - 1);
      exp_issues = (exp_len == 0) ? 0 : (completes ? exp_len : 1);
      if (exp_len == 0)   exp_done = 2;
      else if (completes) exp_done = 2 + exp_len * (m + 3);
      else                exp_done = 2 + TIMEOUT + 1;

      @(negedge clk);
      start    = 1'b1;
      prog_len = 5'(plen);
      if (load_with_start) begin
         w          = rand_word();
         load_valid = 1'b1;
         load_addr  = 4'd0;
         load_data  = w;
         prog_m[0]  = w;
      end
      output_sig = always_on;
      cyc = 0; lowcnt = 0; nissue = 0; prev_low = 0; seen_done = 0;

      while (cyc < exp_done + 20 && !seen_done) begin
         @(negedge clk);
         cyc++;
         start      = 1'b0;
         load_valid = 1'b0;
         if (disturb && cyc == 5) begin
            load_valid = 1'b1;
            load_addr  = 4'd1;
            load_data  = rand_word();
            start      = 1'b1;
            prog_len   = 5'd1;
         end
         read_out1 = 16'($urandom());
         read_out2 = 16'($urandom());
         if (instruct_sig === 1'b0) begin
            if (!prev_low) begin
               lowcnt = 0;
               check("issue_cycle", 64'(cyc), 64'(2 + nissue * (m + 3)));
               check("instruct", instruct, prog_m[nissue % 16]);
               if (nissue == reset_at) begin
                  reset      = 1'b1;
                  output_sig = 1'b0;
                  @(negedge clk);
                  check("abort_sig", instruct_sig, 1);
                  check("abort_busy", busy, 0);
                  check("abort_done", done, 0);
                  check("abort_count", issued_count, 0);
                  reset = 1'b0;
                  done_hits = 0;
                  repeat (4) begin
                     @(negedge clk);
                     if (done === 1'b1) done_hits++;
                  end
                  check("abort_no_done", 64'(done_hits), 0);
                  return;
               end
               nissue++;
            end else begin
               lowcnt++;
            end
            if (lowcnt == m && completes) res_m[(nissue - 1) % 16] = {read_out1, read_out2};
            prev_low = 1;
         end else begin
            prev_low = 0;
         end
         output_sig = always_on || (instruct_sig === 1'b0 && lowcnt >= lat);
         if (done === 1'b1) seen_done = 1;
      end

      check("done_cycle", seen_done ? 64'(cyc) : '1, 64'(exp_done));
      check("issues_seen", 64'(nissue), 64'(exp_issues));
      check("issued_count", issued_count, completes ? 64'(exp_len) : 64'(0));
      check("timeout_err", timeout_err, (!completes && exp_len > 0) ? 1 : 0);
      check("busy_at_done", busy, 0);
      check("sig_at_done", instruct_sig, 1);
      @(negedge clk);
      output_sig = 1'b0;
      check("done_single", done, 0);
      if (completes) begin
         for (int k = 0; k < exp_len; k++) begin
            res_addr = 4'(k);
            #1;
            check("res_data", res_data, res_m[k]);
         end
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_instruct", instruct, 0);
      check("rst_sig", instruct_sig, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_timeout", timeout_err, 0);
      check("rst_count", issued_count, 0);
      reset = 1'b0;

      for (int k = 0; k < 16; k++) load_word(k, rand_word());

      run(3, 3, 0, 0, 0, -1);                    // basic three-instruction program
      run(4, 0, 1, 0, 0, -1);                    // completion flag stuck high
      run(3, 1, 0, 0, 0, -1);                    // early completion inside blanking
      run(2, 1000, 0, 0, 0, -1);                 // processor never answers
      run(1, TIMEOUT - 1, 0, 0, 0, -1);          // completion on the last wait cycle
      run(1, TIMEOUT, 0, 0, 0, -1);              // one cycle too late
      run(0, 3, 0, 0, 0, -1);                    // empty program
      run(20, int'($urandom_range(0, 4)), 0, 0, 0, -1);
      run(3, 3, 0, 0, 0, 1);                     // reset during second instruction
      run(3, int'($urandom_range(0, 5)), 0, 0, 0, -1);
      run(4, 2, 0, 1, 0, -1);                    // load/start while busy
      run(4, int'($urandom_range(0, 5)), 0, 0, 0, -1);
      run(2, int'($urandom_range(0, 5)), 0, 0, 1, -1);
      repeat (6) begin
         load_word(int'($urandom_range(0, 15)), rand_word());
         run(int'($urandom_range(1, 8)), int'($urandom_range(0, 6)), 0, 0, 0, -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
